// File: rtl/fcnn_layer_sequencer_pkg.sv
// pa_fcnn_seq: shared state type and width/saturation helpers for the FC-layer sequencer
package pa_fcnn_seq;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} seq_state_t;
  function automatic int clog2w(input int x);
    return x > 1 ? $clog2(x) : 1;
  endfunction
  function automatic int acc_w(input int dw, input int p);
    return 2 * dw + $clog2(p);
  endfunction
  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction
  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction
endpackage

// File: rtl/fcnn_layer_sequencer_if.sv
// fcnn_layer_sequencer_if: start/done handshake plus weight, activation and output memory ports
interface fcnn_layer_sequencer_if #(
  parameter int dataWidth = 8,
  parameter int NsInPrevLayer = 784,
  parameter int NsInNextLayer = 30
);
  import pa_fcnn_seq::*;
  localparam int WA = clog2w(NsInNextLayer * NsInPrevLayer);
  localparam int AA = clog2w(NsInPrevLayer);
  localparam int OA = clog2w(NsInNextLayer);
  logic start, busy, done, w_rd_en, a_rd_en, o_wr_en;
  logic [WA-1:0] w_addr;
  logic [AA-1:0] a_addr;
  logic [OA-1:0] o_addr;
  logic [dataWidth-1:0] w_data, a_data, o_data;
  modport master (
    input start, w_data, a_data,
    output busy, done, w_rd_en, w_addr, a_rd_en, a_addr, o_wr_en, o_addr, o_data
  );
  modport slave (
    output start, w_data, a_data,
    input busy, done, w_rd_en, w_addr, a_rd_en, a_addr, o_wr_en, o_addr, o_data
  );
endinterface

// File: rtl/fcnn_layer_sequencer_mac_unit.sv
// fcnn_mac_unit: signed MAC with clear, saturating output; FCNN_SEQ_RELU_EN adds ReLU
module fcnn_mac_unit import pa_fcnn_seq::*; #(
  parameter int DW = 8,
  parameter int P = 784
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 rd,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] a,
  output logic signed [DW-1:0] f
);
  localparam int AW = acc_w(DW, P);
  localparam int PW = 2 * DW;
  localparam logic signed [AW-1:0] HI = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] LO = AW'(sat_min(DW));
  logic vld_q, vld_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] sat;
  // read data lands one cycle after the strobe, so the strobe is delayed to qualify it
  always_comb begin
    prod = PW'(w) * PW'(a);
    vld_d = rd;
    acc_d = clr ? '0 : vld_q ? acc_q + AW'(prod) : acc_q;
    sat = acc_q > HI ? DW'(HI) : acc_q < LO ? DW'(LO) : DW'(acc_q);
`ifdef FCNN_SEQ_RELU_EN
    f = sat[DW-1] ? '0 : sat;
`else
    f = sat;
`endif
  end
  always_ff @(posedge clk)
    if (!rst) begin
      vld_q <= 1'b0;
      acc_q <= '0;
    end else begin
      vld_q <= vld_d;
      acc_q <= acc_d;
    end
endmodule

// File: rtl/fcnn_layer_sequencer.sv
// fcnn_layer_sequencer: serial FC-layer controller over one MAC; define FCNN_SEQ_RELU_EN for ReLU output
module fcnn_layer_sequencer import pa_fcnn_seq::*; #(
  parameter int dataWidth = 8,
  parameter int NsInPrevLayer = 784,
  parameter int NsInNextLayer = 30
) (
  input logic clk,
  input logic rst,
  fcnn_layer_sequencer_if.master bus
);
  localparam int P = NsInPrevLayer;
  localparam int N = NsInNextLayer;
  localparam int WA = clog2w(N * P);
  localparam int AA = clog2w(P);
  localparam int OA = clog2w(N);
  seq_state_t state_q, state_d;
  logic [WA-1:0] w_addr_q, w_addr_d;
  logic [AA-1:0] j_q, j_d;
  logic [OA-1:0] i_q, i_d;
  logic run, wr;
  logic signed [dataWidth-1:0] f;
  always_comb begin
    state_d = state_q;
    w_addr_d = w_addr_q;
    j_d = j_q;
    i_d = i_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_RUN;
        w_addr_d = '0;
        j_d = '0;
        i_d = '0;
      end
      S_RUN: begin
        w_addr_d = w_addr_q + WA'(1);
        j_d = j_q + AA'(1);
        if (j_q == AA'(P - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: if (i_q == OA'(N - 1)) state_d = S_DONE;
        else begin
          state_d = S_RUN;
          i_d = i_q + OA'(1);
          j_d = '0;
        end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= S_IDLE;
      w_addr_q <= '0;
      j_q <= '0;
      i_q <= '0;
    end else begin
      state_q <= state_d;
      w_addr_q <= w_addr_d;
      j_q <= j_d;
      i_q <= i_d;
    end
  assign run = state_q == S_RUN;
  assign wr = state_q == S_WRITE;
  assign bus.busy = state_q != S_IDLE;
  assign bus.done = state_q == S_DONE;
  assign bus.w_rd_en = run;
  assign bus.a_rd_en = run;
  assign bus.w_addr = run ? w_addr_q : '0;
  assign bus.a_addr = run ? j_q : '0;
  assign bus.o_wr_en = wr;
  assign bus.o_addr = wr ? i_q : '0;
  assign bus.o_data = wr ? f : '0;
  fcnn_mac_unit #(.DW(dataWidth), .P(P)) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(wr || state_q == S_IDLE),
    .rd(run),
    .w(bus.w_data),
    .a(bus.a_data),
    .f(f)
  );
endmodule

// File: tb/tb_fcnn_layer_sequencer.sv
// tb_fcnn_layer_sequencer: scoreboard bench driving a P=3/N=2 and a P=3/N=1 sequencer
module tb_fcnn_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, base = 0, tests = 0, failed = 0;
`ifdef FCNN_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif
  typedef struct {bit b; bit dn; int addr; int data; int cyc;} ev_t;
  ev_t q[$];
  int wseq[$];
  logic [7:0] wm_a [8];
  logic [7:0] am_a [4];
  logic [7:0] wm_b [4];
  logic [7:0] am_b [4];
  fcnn_layer_sequencer_if #(.dataWidth(8), .NsInPrevLayer(3), .NsInNextLayer(2)) ia ();
  fcnn_layer_sequencer_if #(.dataWidth(8), .NsInPrevLayer(3), .NsInNextLayer(1)) ib ();
  fcnn_layer_sequencer #(.dataWidth(8), .NsInPrevLayer(3), .NsInNextLayer(2)) u_a (
    .clk(clk), .rst(rst), .bus(ia.master));
  fcnn_layer_sequencer #(.dataWidth(8), .NsInPrevLayer(3), .NsInNextLayer(1)) u_b (
    .clk(clk), .rst(rst), .bus(ib.master));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ia.w_rd_en) ia.w_data <= wm_a[ia.w_addr];
    if (ia.a_rd_en) ia.a_data <= am_a[ia.a_addr];
    if (ib.w_rd_en) ib.w_data <= wm_b[ib.w_addr];
    if (ib.a_rd_en) ib.a_data <= am_b[ib.a_addr];
  end
  function automatic int fr(input int v);
    return (RELU && v < 0) ? 0 : v;
  endfunction
  function automatic int outs_a();
    return int'({ia.busy, ia.done, ia.w_rd_en, ia.a_rd_en, ia.o_wr_en, ia.w_addr, ia.a_addr, ia.o_addr, ia.o_data});
  endfunction
  function automatic int outs_b();
    return int'({ib.busy, ib.done, ib.w_rd_en, ib.a_rd_en, ib.o_wr_en, ib.w_addr, ib.a_addr, ib.o_addr, ib.o_data});
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic expw(input bit b, input int addr, input int data, input int c);
    ev_t e;
    e.b = b; e.dn = 1'b0; e.addr = addr; e.data = data; e.cyc = c;
    q.push_back(e);
  endtask
  task automatic expd(input bit b, input int c);
    ev_t e;
    e.b = b; e.dn = 1'b1; e.addr = 0; e.data = 0; e.cyc = c;
    q.push_back(e);
  endtask
  task automatic see(input bit b, input bit dn, input int addr, input int data);
    ev_t e;
    if (q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL unexpected_event: dut %0d done=%0d addr=%0d data=%0d at cycle %0d, expected none",
               b, dn, addr, data, cyc - base + 1);
      return;
    end
    e = q.pop_front();
    chk("event_dut", int'(b), int'(e.b));
    chk("event_kind", int'(dn), int'(e.dn));
    chk("event_cycle", cyc - base + 1, e.cyc);
    if (!e.dn) begin
      chk("o_addr", addr, e.addr);
      chk("o_data", data, e.data);
    end
  endtask
  always @(negedge clk) begin
    if (ia.w_rd_en) wseq.push_back(int'(ia.w_addr));
    if (ia.o_wr_en || ia.done) see(1'b0, ia.done, int'(ia.o_addr), $signed(ia.o_data));
    if (ib.o_wr_en || ib.done) see(1'b1, ib.done, int'(ib.o_addr), $signed(ib.o_data));
  end
  task automatic start_pass(input bit b);
    @(negedge clk);
    if (b) ib.start = 1'b1;
    else ia.start = 1'b1;
    @(posedge clk);
    #1 base = cyc;
    ia.start = 1'b0;
    ib.start = 1'b0;
  endtask
  task automatic pass_b(input logic [7:0] w, input logic [7:0] a, input int exp, input string n);
    for (int k = 0; k < 3; k++) begin
      wm_b[k] = w;
      am_b[k] = a;
    end
    expw(1'b1, 0, exp, 5);
    expd(1'b1, 6);
    start_pass(1'b1);
    repeat (6) @(negedge clk);
    #1 chk(n, q.size(), 0);
    @(negedge clk);
    chk("busy_fall_b", int'(ib.busy), 0);
  endtask
  task automatic load_set2();
    am_a[0] = 8'd2; am_a[1] = 8'hFF; am_a[2] = 8'd4;
    wm_a[0] = 8'd1; wm_a[1] = 8'd1; wm_a[2] = 8'd1;
    wm_a[3] = 8'd3; wm_a[4] = 8'd0; wm_a[5] = 8'hFE;
  endtask
  initial begin
    ia.start = 1'b1;
    ib.start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs_a", outs_a(), 0);
      chk("rst_outputs_b", outs_b(), 0);
    end
    rst = 1'b1;
    ia.start = 1'b0;
    ib.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy_a", int'(ia.busy), 0);
    chk("idle_busy_b", int'(ib.busy), 0);
    for (int k = 0; k < 6; k++) wm_a[k] = 8'd1;
    am_a[0] = 8'd1; am_a[1] = 8'd2; am_a[2] = 8'd3;
    wseq.delete();
    expw(1'b0, 0, 6, 5);
    expw(1'b0, 1, 6, 10);
    expd(1'b0, 11);
    start_pass(1'b0);
    repeat (11) @(negedge clk);
    #1 chk("basic_events_left", q.size(), 0);
    @(negedge clk);
    chk("basic_busy_fall", int'(ia.busy), 0);
    chk("w_addr_count", wseq.size(), 6);
    for (int k = 0; k < 6; k++) chk("w_addr_seq", k < wseq.size() ? wseq[k] : -1, k);
    pass_b(8'd127, 8'd127, 127, "sat_hi_events_left");
    pass_b(8'h80, 8'd127, fr(-128), "sat_lo_events_left");
    pass_b(8'hFF, 8'd5, fr(-15), "relu_events_left");
    load_set2();
    expw(1'b0, 0, 5, 5);
    expw(1'b0, 1, fr(-2), 10);
    expd(1'b0, 11);
    expw(1'b0, 0, 5, 17);
    expw(1'b0, 1, fr(-2), 22);
    expd(1'b0, 23);
    start_pass(1'b0);
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      ia.start = (c == 3 || c == 11 || c == 12);
      if (c == 12) chk("restart_idle_rd", int'(ia.w_rd_en), 0);
      if (c == 13) begin
        chk("restart_first_rd", int'(ia.w_rd_en), 1);
        chk("restart_first_addr", int'(ia.w_addr), 0);
      end
    end
    #1 chk("handshake_events_left", q.size(), 0);
    start_pass(1'b0);
    repeat (4) @(negedge clk);
    chk("mid_busy", int'(ia.busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_idle", int'({ia.busy, ia.w_rd_en, ia.a_rd_en, ia.o_wr_en}), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", int'(ia.busy), 0);
    expw(1'b0, 0, 5, 5);
    expw(1'b0, 1, fr(-2), 10);
    expd(1'b0, 11);
    start_pass(1'b0);
    repeat (11) @(negedge clk);
    #1 chk("fresh_events_left", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
